// File: rtl/actor_mover_pkg.sv
// Shared types for the actor mover.
//   dir_t   : movement direction encoding (matches the 2-bit dir port)
//   state_t : step-attempt FSM states
package actor_mover_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHK_WANT = 2'd1,
        CHK_CUR  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

endpackage

// File: rtl/actor_mover_neighbour.sv
// grid_neighbour: combinational neighbour of a grid tile in a given direction.
//   row, col          : current tile
//   dir               : direction to step
//   nb_row, nb_col    : neighbouring tile (wrapped to the far edge at a border)
//   off_edge          : 1 = step leaves the grid and edges are walls (WRAP_EN=0)
module grid_neighbour
    import actor_mover_pkg::*;
#(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 30,
    parameter int WRAP_EN = 1,
    parameter int ROW_W   = 5,
    parameter int COL_W   = 5
) (
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    input  dir_t             dir,
    output logic [ROW_W-1:0] nb_row,
    output logic [COL_W-1:0] nb_col,
    output logic             off_edge
);

    always_comb begin
        nb_row   = row;
        nb_col   = col;
        off_edge = 1'b0;
        case (dir)
            UP: begin
                if (row == '0) begin
                    nb_row   = ROW_W'(GRID_H - 1);
                    off_edge = (WRAP_EN == 0);
                end else begin
                    nb_row = row - ROW_W'(1);
                end
            end
            DOWN: begin
                if (row == ROW_W'(GRID_H - 1)) begin
                    nb_row   = '0;
                    off_edge = (WRAP_EN == 0);
                end else begin
                    nb_row = row + ROW_W'(1);
                end
            end
            LEFT: begin
                if (col == '0) begin
                    nb_col   = COL_W'(GRID_W - 1);
                    off_edge = (WRAP_EN == 0);
                end else begin
                    nb_col = col - COL_W'(1);
                end
            end
            RIGHT: begin
                if (col == COL_W'(GRID_W - 1)) begin
                    nb_col   = '0;
                    off_edge = (WRAP_EN == 0);
                end else begin
                    nb_col = col + COL_W'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/actor_mover.sv
// actor_mover: moves an actor one tile every MOVE_DIV step ticks, preferring
// the buffered joystick direction and falling back to the current direction,
// asking an external wall map (chk_req/chk_idx -> chk_ack/chk_wall) first.
//   clk, reset_n              : clock, async active-low reset
//   enable, tick              : run/freeze, step strobe
//   up/down/left/right        : joystick (only a single press is accepted)
//   load, load_idx            : respawn at a tile (highest priority)
//   chk_req, chk_idx          : wall lookup request, held until chk_ack
//   chk_ack, chk_wall         : lookup result
//   pos_idx, dir              : current tile (row*GRID_W+col) and direction
//   moving, step_done         : last attempt moved, attempt-finished pulse
module actor_mover
    import actor_mover_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 30,
    parameter int IDX_W    = 10,
    parameter int MOVE_DIV = 8,
    parameter int WRAP_EN  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    output logic             chk_req,
    output logic [IDX_W-1:0] chk_idx,
    input  logic             chk_ack,
    input  logic             chk_wall,
    output logic [IDX_W-1:0] pos_idx,
    output logic [1:0]       dir,
    output logic             moving,
    output logic             step_done
);

    localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    state_t           state, state_nx;
    logic [ROW_W-1:0] row, nb_row;
    logic [COL_W-1:0] col, nb_col;
    logic             nb_off;
    dir_t             dir_q, want_dir, sel_dir, joy_dir;
    logic [3:0]       joy;
    logic [CNT_W-1:0] tick_cnt;
    logic             pending, tick_hit, start;
    logic             take_want, do_commit, blocked;

    function automatic logic [IDX_W-1:0] to_idx(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
        return IDX_W'(r) * IDX_W'(GRID_W) + IDX_W'(c);
    endfunction

    assign dir = dir_q;

    // One neighbour unit serves every state: the wanted direction while
    // probing it, the current direction otherwise. By COMMIT, dir_q already
    // holds the direction that was found open, so the target is recomputed.
    assign sel_dir = (state == CHK_WANT) ? want_dir : dir_q;

    grid_neighbour #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .WRAP_EN(WRAP_EN),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_nb (
        .row     (row),
        .col     (col),
        .dir     (sel_dir),
        .nb_row  (nb_row),
        .nb_col  (nb_col),
        .off_edge(nb_off)
    );

    assign joy = {right, left, down, up};

    always_comb begin
        joy_dir = RIGHT;
        if (joy[0])      joy_dir = UP;
        else if (joy[1]) joy_dir = DOWN;
        else if (joy[2]) joy_dir = LEFT;
    end

    assign tick_hit = enable && tick && (tick_cnt == CNT_W'(MOVE_DIV - 1));
    assign start    = enable && (state == IDLE) && (pending || tick_hit);

    // Lookup is driven straight from the state, so it drops the cycle the
    // FSM leaves a check state (load, ack) or the moment reset asserts.
    always_comb begin
        chk_req = 1'b0;
        if (state == CHK_CUR || (state == CHK_WANT && want_dir != dir_q))
            chk_req = !nb_off;
    end

    assign chk_idx = chk_req ? to_idx(nb_row, nb_col) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        take_want = 1'b0;
        do_commit = 1'b0;
        blocked   = 1'b0;
        case (state)
            IDLE: if (start) state_nx = CHK_WANT;
            CHK_WANT: begin
                // Nothing new to try, or the wanted tile is past a wall edge.
                if (want_dir == dir_q || nb_off) begin
                    state_nx = CHK_CUR;
                end else if (chk_ack) begin
                    if (chk_wall) begin
                        state_nx = CHK_CUR;
                    end else begin
                        state_nx  = COMMIT;
                        take_want = 1'b1;
                    end
                end
            end
            CHK_CUR: begin
                if (nb_off || (chk_ack && chk_wall)) begin
                    state_nx = IDLE;
                    blocked  = 1'b1;
                end else if (chk_ack) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                state_nx  = IDLE;
                do_commit = 1'b1;
            end
        endcase
        if (load) begin
            state_nx  = IDLE;
            take_want = 1'b0;
            do_commit = 1'b0;
            blocked   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row       <= '0;
            col       <= '0;
            pos_idx   <= '0;
            dir_q     <= RIGHT;
            want_dir  <= RIGHT;
            tick_cnt  <= '0;
            pending   <= 1'b0;
            moving    <= 1'b0;
            step_done <= 1'b0;
        end else begin
            if ($onehot(joy)) want_dir <= joy_dir;
            if (load) begin
                row       <= ROW_W'(load_idx / IDX_W'(GRID_W));
                col       <= COL_W'(load_idx % IDX_W'(GRID_W));
                pos_idx   <= load_idx;
                tick_cnt  <= '0;
                pending   <= 1'b0;
                moving    <= 1'b0;
                step_done <= 1'b0;
            end else begin
                step_done <= do_commit | blocked;
                if (tick_hit)            tick_cnt <= '0;
                else if (enable && tick) tick_cnt <= tick_cnt + CNT_W'(1);
                // A start consumes the pending slot; a hit mid-attempt fills it.
                pending <= start ? (pending & tick_hit) : (pending | tick_hit);
                if (take_want) dir_q <= want_dir;
                if (do_commit) begin
                    row     <= nb_row;
                    col     <= nb_col;
                    pos_idx <= to_idx(nb_row, nb_col);
                    moving  <= 1'b1;
                end
                if (blocked) moving <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_actor_mover.sv
// Directed bench for actor_mover: one wrapping instance (dut) and one walled
// instance (dut0) share stimulus; the wall map answers lookups either
// instantly (auto_ack) or by hand (man_ack/man_wall).
module tb_actor_mover;

    logic       clk = 1'b0;
    logic       reset_n, enable, tick, up, down, left, right, load;
    logic [9:0] load_idx;

    logic       chk_req, chk_ack, chk_wall, moving, step_done;
    logic [9:0] chk_idx, pos_idx;
    logic [1:0] dir;
    logic       chk_req0, chk_ack0, chk_wall0, moving0, step_done0;
    logic [9:0] chk_idx0, pos_idx0;
    logic [1:0] dir0;

    logic       auto_ack, man_ack, man_wall;
    logic       wall_map [0:1023];
    int         errors = 0, checks = 0, req0_cnt = 0, req0_base;

    always #5 clk = ~clk;

    assign chk_ack   = auto_ack ? chk_req : man_ack;
    assign chk_wall  = auto_ack ? wall_map[chk_idx] : man_wall;
    assign chk_ack0  = auto_ack ? chk_req0 : man_ack;
    assign chk_wall0 = auto_ack ? wall_map[chk_idx0] : man_wall;

    always @(posedge clk) if (chk_req0) req0_cnt <= req0_cnt + 1;

    actor_mover #(.WRAP_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick),
        .up(up), .down(down), .left(left), .right(right),
        .load(load), .load_idx(load_idx),
        .chk_req(chk_req), .chk_idx(chk_idx), .chk_ack(chk_ack), .chk_wall(chk_wall),
        .pos_idx(pos_idx), .dir(dir), .moving(moving), .step_done(step_done)
    );

    actor_mover #(.WRAP_EN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick),
        .up(up), .down(down), .left(left), .right(right),
        .load(load), .load_idx(load_idx),
        .chk_req(chk_req0), .chk_idx(chk_idx0), .chk_ack(chk_ack0), .chk_wall(chk_wall0),
        .pos_idx(pos_idx0), .dir(dir0), .moving(moving0), .step_done(step_done0)
    );

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic tick_n(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        up = u; down = d; left = l; right = r;
        @(negedge clk);
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    endtask

    task automatic load_pos(input logic [9:0] idx);
        load = 1'b1; load_idx = idx;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) wall_map[i] = 1'b0;
        reset_n = 1'b0; enable = 1'b1; tick = 1'b0; load = 1'b0; load_idx = '0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        auto_ack = 1'b1; man_ack = 1'b0; man_wall = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        ck("rst_pos", pos_idx, 0);
        ck("rst_dir", dir, 3);
        ck("rst_req", chk_req, 0);
        ck("rst_idx", chk_idx, 0);
        ck("rst_mov", moving, 0);
        ck("rst_done", step_done, 0);
        reset_n = 1'b1;

        // Right held, open map: move 0 -> 1 three cycles after the 8th tick
        right = 1'b1;
        tick_n(8);
        @(negedge clk); ck("t1_done_a", step_done, 0);
        @(negedge clk); ck("t1_done_b", step_done, 0); ck("t1_pos_b", pos_idx, 0);
        @(negedge clk); ck("t1_done", step_done, 1); ck("t1_pos", pos_idx, 1);
        ck("t1_mov", moving, 1);
        @(negedge clk); ck("t1_pulse", step_done, 0);
        right = 1'b0;

        // pos 33 heading right, press up; tile 1 wall, tile 34 open
        load_pos(10'd33);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        auto_ack = 1'b0;
        tick_n(8);
        ck("t2_want_req", chk_req, 1);
        ck("t2_want_idx", chk_idx, 1);
        man_ack = 1'b1; man_wall = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        ck("t2_cur_req", chk_req, 1);
        ck("t2_cur_idx", chk_idx, 34);
        man_ack = 1'b1; man_wall = 1'b0;
        @(negedge clk);
        man_ack = 1'b0;
        ck("t2_commit_done", step_done, 0);
        @(negedge clk);
        ck("t2_pos", pos_idx, 34);
        ck("t2_dir", dir, 3);
        ck("t2_done", step_done, 1);

        // pos 31 heading right: wrap to 0 vs wall edge
        press(1'b0, 1'b0, 1'b0, 1'b1);
        load_pos(10'd31);
        auto_ack = 1'b1;
        req0_base = req0_cnt;
        tick_n(8);
        @(negedge clk); ck("t3_w0_done_a", step_done0, 0);
        @(negedge clk); ck("t3_w0_done", step_done0, 1); ck("t3_w0_pos", pos_idx0, 31);
        ck("t3_w0_mov", moving0, 0); ck("t3_w1_done_a", step_done, 0);
        @(negedge clk); ck("t3_w1_done", step_done, 1); ck("t3_w1_pos", pos_idx, 0);
        ck("t3_w1_mov", moving, 1); ck("t3_w0_pulse", step_done0, 0);
        ck("t3_w0_noreq", req0_cnt - req0_base, 0);

        // Ack delayed 5 cycles: request held stable, commit one cycle after ack
        auto_ack = 1'b0;
        tick_n(8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ck("t4_req_hold", chk_req, 1);
            ck("t4_idx_hold", chk_idx, 1);
        end
        man_ack = 1'b1; man_wall = 1'b0;
        @(negedge clk);
        man_ack = 1'b0;
        ck("t4_commit_done", step_done, 0);
        @(negedge clk);
        ck("t4_pos", pos_idx, 1);
        ck("t4_done", step_done, 1);

        // Load during CHK_WANT, then a stray ack
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(8);
        ck("t5_want_req", chk_req, 1);
        ck("t5_want_idx", chk_idx, 929);
        load_pos(10'd100);
        ck("t5_req_drop", chk_req, 0);
        ck("t5_pos", pos_idx, 100);
        ck("t5_mov", moving, 0);
        ck("t5_done", step_done, 0);
        man_ack = 1'b1; man_wall = 1'b0;
        @(negedge clk);
        man_ack = 1'b0;
        ck("t5_stray_done", step_done, 0);
        @(negedge clk);
        ck("t5_stray_done_b", step_done, 0);
        ck("t5_stray_pos", pos_idx, 100);

        // Reset mid-lookup acts without a clock edge
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tick_n(8);
        @(negedge clk);
        ck("t6_req", chk_req, 1);
        ck("t6_idx", chk_idx, 101);
        #2 reset_n = 1'b0;
        #1;
        ck("t6_async_pos", pos_idx, 0);
        ck("t6_async_dir", dir, 3);
        ck("t6_async_req", chk_req, 0);
        ck("t6_async_idx", chk_idx, 0);
        ck("t6_async_mov", moving, 0);
        ck("t6_async_done", step_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        ck("t6_stray_pos", pos_idx, 0);
        ck("t6_stray_done", step_done, 0);

        // Two buttons at once are ignored: still goes right
        auto_ack = 1'b1;
        press(1'b1, 1'b1, 1'b0, 1'b0);
        tick_n(8);
        repeat (3) @(negedge clk);
        ck("t7_pos", pos_idx, 1);
        ck("t7_dir", dir, 3);
        ck("t7_done", step_done, 1);

        // enable=0 holds the tick count
        tick_n(4);
        enable = 1'b0;
        tick_n(8);
        repeat (3) @(negedge clk);
        ck("t8_frozen_pos", pos_idx, 1);
        ck("t8_frozen_done", step_done, 0);
        enable = 1'b1;
        tick_n(4);
        @(negedge clk);
        @(negedge clk); ck("t8_done_a", step_done, 0);
        @(negedge clk); ck("t8_done", step_done, 1); ck("t8_pos", pos_idx, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/actor_mover.md
ACTOR_MOVER -- requirements
Module: actor_mover

Interface
REQ-001 Parameter GRID_W, default 32, grid columns.
REQ-002 Parameter GRID_H, default 30, grid rows.
REQ-003 Parameter IDX_W, default 10, tile index width; must satisfy 2**IDX_W >= GRID_W*GRID_H.
REQ-004 Parameter MOVE_DIV, default 8, step ticks per tile move (>=1).
REQ-005 Parameter WRAP_EN, default 1, 1 = wrap at grid edges (tunnel), 0 = edges are walls.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  1 = movement runs, 0 = frozen.
REQ-009 tick  input  1  one-cycle step strobe (frame/step rate).
REQ-010 up, down, left, right  input  1 each  joystick request; valid only when exactly one is high.
REQ-011 load  input  1  respawn strobe.
REQ-012 load_idx  input  IDX_W  respawn tile.
REQ-013 chk_req  output  1  wall lookup request.
REQ-014 chk_idx  output  IDX_W  tile being looked up.
REQ-015 chk_ack  input  1  lookup result valid, one cycle.
REQ-016 chk_wall  input  1  1 = tile at chk_idx is wall, sampled with chk_ack.
REQ-017 pos_idx  output  IDX_W  current tile, row*GRID_W+col.
REQ-018 dir  output  2  current direction, 0=up, 1=down, 2=left, 3=right.
REQ-019 moving  output  1  1 = last step attempt moved.
REQ-020 step_done  output  1  one-cycle pulse when a step attempt finishes, moved or blocked.

Function
REQ-021 Row/col SHALL be held internally; pos_idx SHALL be registered row*GRID_W+col.
REQ-022 Buffered direction want_dir SHALL latch on any cycle with exactly one of up/down/left/right high; none high or more than one high SHALL leave it unchanged.
REQ-023 Tick counter SHALL count tick pulses while enable=1 and SHALL start a step attempt on the MOVE_DIV-th tick, then clear.
REQ-024 FSM states: IDLE, CHK_WANT, CHK_CUR, COMMIT.
REQ-025 IDLE -> CHK_WANT on step start; chk_idx = neighbour of current tile in want_dir.
REQ-026 CHK_WANT: chk_req SHALL stay high with chk_idx stable until chk_ack; open -> COMMIT with dir<=want_dir; wall -> CHK_CUR.
REQ-027 CHK_WANT SHALL skip straight to CHK_CUR if want_dir equals dir.
REQ-028 CHK_CUR: look up neighbour in dir; open -> COMMIT; wall -> IDLE with moving<=0 and step_done pulse.
REQ-029 COMMIT: update row/col to the target, moving<=1, step_done pulse, -> IDLE; exactly one cycle.
REQ-030 Edge handling: col 0 left / col GRID_W-1 right / row 0 up / row GRID_H-1 down SHALL wrap to the opposite edge when WRAP_EN=1; when WRAP_EN=0 the neighbour SHALL be treated as wall with no lookup issued (chk_req stays low).
REQ-031 chk_ack outside CHK_WANT/CHK_CUR SHALL be ignored.
REQ-032 load SHALL take priority over everything: pos<=load_idx, abort any lookup (chk_req low next cycle), FSM -> IDLE, tick counter cleared, moving<=0, no step_done.
REQ-033 enable=0 SHALL hold the tick counter; an in-flight lookup SHALL still complete and commit.
REQ-034 Ticks arriving during an attempt SHALL still be counted; a step start while not in IDLE SHALL be deferred until IDLE (at most one pending).

Reset
REQ-035 reset_n low SHALL asynchronously force: FSM IDLE, row/col 0 (pos_idx 0), dir 3 (right), want_dir 3, tick count 0, pending 0, chk_req 0, chk_idx 0, moving 0, step_done 0.
REQ-036 Reset during an outstanding lookup SHALL drop it; a later chk_ack SHALL have no effect.

Structure
REQ-037 Shared package SHALL hold the dir_t encoding (UP/DOWN/LEFT/RIGHT) and the FSM state typedef.
REQ-038 Neighbour/wrap computation SHALL be one combinational sub-module, grid_neighbour (row, col, dir -> row, col, off_edge).

Verification
REQ-039 Reset, pos 0, right held, open map, MOVE_DIV=8: pos_idx 1 after 8th tick, step_done one pulse, moving=1.
REQ-040 pos 33 dir right, press up, tile 1 wall, tile 34 open: CHK_WANT then CHK_CUR, pos 34, dir stays right.
REQ-041 pos 31 right, WRAP_EN=1: pos 0; WRAP_EN=0: no chk_req, pos 31, moving=0, step_done pulse.
REQ-042 chk_ack delayed 5 cycles: chk_req and chk_idx stable all 5 cycles, commit one cycle after ack.
REQ-043 load_idx=100 asserted mid-CHK_WANT, then stray chk_ack: pos 100, no step_done, no move.
REQ-044 reset_n low mid-lookup for 1 cycle: all outputs at reset values immediately, not waiting for clk.
